// File: rtl/fetch_sequencer_pkg.sv
// Shared processor-wide fetch definitions: default widths, reset address,
// and the fetch sequencer state encoding.
package fetch_sequencer_pkg;

   localparam int FETCH_AWIDTH     = 6;
   localparam int FETCH_RWIDTH     = 32;
   localparam int FETCH_RESET_ADDR = 0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2,
      S_DRAIN = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with redirect load, increment, and hold.
// Load wins over increment; pc_next exposes the value being registered.
module fetch_pc_reg
   import fetch_sequencer_pkg::*;
#(
   parameter int AWIDTH     = FETCH_AWIDTH,
   parameter int RESET_ADDR = FETCH_RESET_ADDR
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [AWIDTH-1:0] load_addr,
   input  logic              incr,
   output logic [AWIDTH-1:0] pc_next,
   output logic [AWIDTH-1:0] pc
);

   logic [AWIDTH-1:0] pc_d;
   logic [AWIDTH-1:0] pc_q;

   always_comb begin
      pc_d = pc_q;
      if (load) begin
         pc_d = load_addr;
      end else if (incr) begin
         pc_d = pc_q + AWIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= AWIDTH'(RESET_ADDR);
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_next = pc_d;
   assign pc      = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues req/ack memory reads and
// hands fetched words to decode over valid/ready, with run control and redirects.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | no request outstanding, waiting for run
//   S_FETCH | imem_req high at imem_addr == pc, waiting for ack
//   S_HOLD  | inst_valid high, waiting for decode to accept
//   S_DRAIN | redirected while a read was outstanding; finish and drop it
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int AWIDTH     = FETCH_AWIDTH,
   parameter int RWIDTH     = FETCH_RWIDTH,
   parameter int RESET_ADDR = FETCH_RESET_ADDR
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic              redirect_valid,
   input  logic [AWIDTH-1:0] redirect_addr,
   output logic              imem_req,
   output logic [AWIDTH-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [RWIDTH-1:0] imem_rdata,
   output logic              inst_valid,
   output logic [RWIDTH-1:0] inst_data,
   output logic [AWIDTH-1:0] inst_pc,
   input  logic              inst_ready,
   output logic [AWIDTH-1:0] pc
);

   fetch_state_e      state_d, state_q;
   logic              imem_req_d, imem_req_q;
   logic [AWIDTH-1:0] imem_addr_d, imem_addr_q;
   logic              inst_valid_d, inst_valid_q;
   logic [RWIDTH-1:0] inst_data_d, inst_data_q;
   logic [AWIDTH-1:0] inst_pc_d, inst_pc_q;

   logic              pc_incr;
   logic [AWIDTH-1:0] pc_next;
   logic              mem_xfer;
   logic              dec_xfer;

   fetch_pc_reg #(
      .AWIDTH     (AWIDTH),
      .RESET_ADDR (RESET_ADDR)
   ) u_pc_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (redirect_valid),
      .load_addr (redirect_addr),
      .incr      (pc_incr),
      .pc_next   (pc_next),
      .pc        (pc)
   );

   assign mem_xfer = imem_req_q & imem_ack;
   assign dec_xfer = inst_valid_q & inst_ready;

   always_comb begin
      state_d      = state_q;
      imem_req_d   = imem_req_q;
      inst_valid_d = inst_valid_q;
      inst_data_d  = inst_data_q;
      inst_pc_d    = inst_pc_q;
      pc_incr      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!redirect_valid && run) begin
               state_d    = S_FETCH;
               imem_req_d = 1'b1;
            end
         end
         S_FETCH: begin
            if (redirect_valid) begin
               if (mem_xfer) begin
                  state_d    = run ? S_FETCH : S_IDLE;
                  imem_req_d = run;
               end else begin
                  state_d = S_DRAIN;
               end
            end else if (mem_xfer) begin
               state_d      = S_HOLD;
               imem_req_d   = 1'b0;
               inst_valid_d = 1'b1;
               inst_data_d  = imem_rdata;
               inst_pc_d    = pc;
               pc_incr      = 1'b1;
            end
         end
         S_HOLD: begin
            if (redirect_valid || dec_xfer) begin
               inst_valid_d = 1'b0;
               state_d      = run ? S_FETCH : S_IDLE;
               imem_req_d   = run;
            end
         end
         S_DRAIN: begin
            if (mem_xfer) begin
               state_d    = run ? S_FETCH : S_IDLE;
               imem_req_d = run;
            end
         end
         default: begin
            state_d      = S_IDLE;
            imem_req_d   = 1'b0;
            inst_valid_d = 1'b0;
         end
      endcase

      // The drained read keeps its original address; otherwise track the PC.
      imem_addr_d = (state_d == S_DRAIN) ? imem_addr_q : pc_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         imem_req_q   <= 1'b0;
         imem_addr_q  <= AWIDTH'(RESET_ADDR);
         inst_valid_q <= 1'b0;
         inst_data_q  <= '0;
         inst_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         imem_req_q   <= imem_req_d;
         imem_addr_q  <= imem_addr_d;
         inst_valid_q <= inst_valid_d;
         inst_data_q  <= inst_data_d;
         inst_pc_q    <= inst_pc_d;
      end
   end

   assign imem_req   = imem_req_q;
   assign imem_addr  = imem_addr_q;
   assign inst_valid = inst_valid_q;
   assign inst_data  = inst_data_q;
   assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected memory reads and decode
// deliveries are queued by the stimulus and popped by independent monitors.
module tb_fetch_sequencer;

   localparam int AW = 6;
   localparam int RW = 32;

   logic          clk;
   logic          rst_n;
   logic          run;
   logic          redirect_valid;
   logic [AW-1:0] redirect_addr;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack;
   logic [RW-1:0] imem_rdata;
   logic          inst_valid;
   logic [RW-1:0] inst_data;
   logic [AW-1:0] inst_pc;
   logic          inst_ready;
   logic [AW-1:0] pc;

   logic          ack_en;
   int            n_checks;
   int            n_pass;

   logic [AW-1:0] mem_q[$];
   logic [AW-1:0] exp_pc_q[$];
   logic [RW-1:0] exp_data_q[$];

   fetch_sequencer #(.AWIDTH(AW), .RWIDTH(RW), .RESET_ADDR(0)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .run            (run),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .inst_valid     (inst_valid),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready),
      .pc             (pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM contents: word[i] = i + 100
   assign imem_ack   = ack_en;
   assign imem_rdata = 32'(imem_addr) + 32'd100;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_inst(input logic [AW-1:0] a);
      exp_pc_q.push_back(a);
      exp_data_q.push_back(32'(a) + 32'd100);
   endtask

   always @(negedge clk) begin
      if (rst_n && imem_req && imem_ack) begin
         if (mem_q.size() == 0) begin
            n_checks++;
            $display("FAIL mem_read: unexpected read at addr %0h, none expected", imem_addr);
         end else begin
            chk("mem_read_addr", 64'(imem_addr), 64'(mem_q.pop_front()));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && inst_valid && inst_ready) begin
         if (exp_pc_q.size() == 0) begin
            n_checks++;
            $display("FAIL delivery: unexpected inst pc=%0h data=%0h, none expected", inst_pc, inst_data);
         end else begin
            chk("deliver_pc", 64'(inst_pc), 64'(exp_pc_q.pop_front()));
            chk("deliver_data", 64'(inst_data), 64'(exp_data_q.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pc"},         64'(pc), 64'd0);
      chk({tag, "_imem_req"},   64'(imem_req), 64'd0);
      chk({tag, "_imem_addr"},  64'(imem_addr), 64'd0);
      chk({tag, "_inst_valid"}, 64'(inst_valid), 64'd0);
      chk({tag, "_inst_data"},  64'(inst_data), 64'd0);
      chk({tag, "_inst_pc"},    64'(inst_pc), 64'd0);
   endtask

   initial begin
      n_checks = 0;
      n_pass = 0;
      rst_n = 1'b0;
      run = 1'b0;
      redirect_valid = 1'b0;
      redirect_addr = '0;
      ack_en = 1'b0;
      inst_ready = 1'b0;
      #12;
      chk_reset_vals("reset");
      @(negedge clk) rst_n = 1'b1;
      tick();

      // Streaming: zero-wait memory, decode always ready
      for (int i = 0; i < 4; i++) begin
         mem_q.push_back(AW'(i));
         push_inst(AW'(i));
      end
      ack_en = 1'b1;
      inst_ready = 1'b1;
      run = 1'b1;
      chk("stream_req_before", 64'(imem_req), 64'd0);
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (c == 1) chk("stream_first_req", 64'(imem_req), 64'd1);
         chk("stream_valid_pattern", 64'(inst_valid), 64'(c % 2 == 0));
      end
      run = 1'b0;
      tick();
      tick();
      chk("stream_idle_req", 64'(imem_req), 64'd0);
      chk("stream_pc", 64'(pc), 64'd4);

      // Redirect in IDLE, then wrap around the top of the address space
      redirect_valid = 1'b1;
      redirect_addr = AW'(62);
      tick();
      redirect_valid = 1'b0;
      chk("idle_redirect_pc", 64'(pc), 64'd62);
      chk("idle_redirect_req", 64'(imem_req), 64'd0);
      mem_q.push_back(AW'(62)); mem_q.push_back(AW'(63)); mem_q.push_back(AW'(0));
      push_inst(AW'(62)); push_inst(AW'(63)); push_inst(AW'(0));
      run = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (c == 2) chk("wrap_pc_63", 64'(pc), 64'd63);
         if (c == 4) chk("wrap_pc_0", 64'(pc), 64'd0);
         if (c == 6) chk("wrap_pc_1", 64'(pc), 64'd1);
      end
      run = 1'b0;
      tick();
      tick();
      chk("wrap_idle_req", 64'(imem_req), 64'd0);

      // Slow memory then decode stall
      mem_q.push_back(AW'(1)); mem_q.push_back(AW'(2));
      push_inst(AW'(1)); push_inst(AW'(2));
      ack_en = 1'b0;
      inst_ready = 1'b0;
      run = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         tick();
         chk("wait_req", 64'(imem_req), 64'd1);
         chk("wait_addr_stable", 64'(imem_addr), 64'd1);
         chk("wait_no_valid", 64'(inst_valid), 64'd0);
      end
      ack_en = 1'b1;
      tick();
      chk("ack_valid", 64'(inst_valid), 64'd1);
      chk("ack_req_drop", 64'(imem_req), 64'd0);
      for (int c = 1; c <= 4; c++) begin
         tick();
         chk("stall_valid", 64'(inst_valid), 64'd1);
         chk("stall_pc", 64'(inst_pc), 64'd1);
         chk("stall_data", 64'(inst_data), 64'd101);
         chk("stall_no_req", 64'(imem_req), 64'd0);
      end
      inst_ready = 1'b1;
      tick();
      chk("release_valid", 64'(inst_valid), 64'd0);
      chk("release_req", 64'(imem_req), 64'd1);
      chk("release_addr", 64'(imem_addr), 64'd2);
      run = 1'b0;
      tick();
      tick();
      tick();
      chk("stall_idle_req", 64'(imem_req), 64'd0);
      chk("stall_idle_pc", 64'(pc), 64'd3);

      // Redirect during FETCH before the ack: old read drained and dropped
      mem_q.push_back(AW'(3)); mem_q.push_back(AW'(32));
      push_inst(AW'(32));
      ack_en = 1'b0;
      run = 1'b1;
      tick();
      chk("drain_req", 64'(imem_addr), 64'd3);
      redirect_valid = 1'b1;
      redirect_addr = AW'(32);
      tick();
      redirect_valid = 1'b0;
      chk("drain_pc", 64'(pc), 64'd32);
      chk("drain_old_addr", 64'(imem_addr), 64'd3);
      chk("drain_req_high", 64'(imem_req), 64'd1);
      tick();
      chk("drain_no_valid", 64'(inst_valid), 64'd0);
      ack_en = 1'b1;
      tick();
      chk("drain_discard", 64'(inst_valid), 64'd0);
      chk("drain_new_addr", 64'(imem_addr), 64'd32);
      chk("drain_new_req", 64'(imem_req), 64'd1);
      tick();
      chk("drain_deliver_valid", 64'(inst_valid), 64'd1);
      chk("drain_deliver_pc", 64'(inst_pc), 64'd32);
      run = 1'b0;
      tick();
      tick();
      chk("drain_idle_pc", 64'(pc), 64'd33);

      // Redirect in HOLD: first with decode stalled, then with decode accepting
      mem_q.push_back(AW'(33)); mem_q.push_back(AW'(16)); mem_q.push_back(AW'(16));
      push_inst(AW'(16)); push_inst(AW'(16));
      inst_ready = 1'b0;
      run = 1'b1;
      tick();
      tick();
      chk("hold_valid", 64'(inst_valid), 64'd1);
      chk("hold_inst_pc", 64'(inst_pc), 64'd33);
      redirect_valid = 1'b1;
      redirect_addr = AW'(16);
      tick();
      redirect_valid = 1'b0;
      chk("flush_valid", 64'(inst_valid), 64'd0);
      chk("flush_addr", 64'(imem_addr), 64'd16);
      chk("flush_pc", 64'(pc), 64'd16);
      inst_ready = 1'b1;
      tick();
      chk("flush_refetch_pc", 64'(inst_pc), 64'd16);
      redirect_valid = 1'b1;
      redirect_addr = AW'(16);
      tick();
      redirect_valid = 1'b0;
      chk("flush_rdy_valid", 64'(inst_valid), 64'd0);
      chk("flush_rdy_req", 64'(imem_req), 64'd1);
      chk("flush_rdy_addr", 64'(imem_addr), 64'd16);
      tick();
      run = 1'b0;
      tick();
      tick();
      chk("flush_idle_req", 64'(imem_req), 64'd0);
      chk("flush_idle_valid", 64'(inst_valid), 64'd0);

      // Asynchronous reset mid-FETCH and mid-HOLD
      ack_en = 1'b0;
      inst_ready = 1'b0;
      run = 1'b1;
      tick();
      chk("pre_rst_req", 64'(imem_req), 64'd1);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("rst_fetch");
      @(negedge clk) rst_n = 1'b1;
      tick();
      chk("restart_req", 64'(imem_req), 64'd1);
      chk("restart_addr", 64'(imem_addr), 64'd0);
      mem_q.push_back(AW'(0));
      ack_en = 1'b1;
      tick();
      chk("pre_rst_hold_valid", 64'(inst_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("rst_hold");
      mem_q.push_back(AW'(0));
      push_inst(AW'(0));
      inst_ready = 1'b1;
      @(negedge clk) rst_n = 1'b1;
      tick();
      tick();
      chk("restart2_pc", 64'(inst_pc), 64'd0);
      chk("restart2_data", 64'(inst_data), 64'd100);
      run = 1'b0;
      tick();
      tick();

      chk("mem_queue_empty", 64'(mem_q.size()), 64'd0);
      chk("inst_queue_empty", 64'(exp_pc_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
